// File: rtl/tx_relatorio_serial_8n1.sv
// -----------------------------------------------------------------------------
// tx_relatorio_serial_8n1
//
// Serializes an elevator status report on an 8N1 line. A start request sends
// a header byte with the current floor, then one byte per occupied slot of the
// elevator-content RAM (ascending address order), then a trailer byte 8'hFE.
// Byte layout: [1:0] floor, [3:2] destination, [5:4] object type, [7:6] marker.
//
// Parameters:
//   BAUD_DIV      clocks per serial bit
//   N_ITENS       number of content-RAM slots scanned (1..16)
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-low reset
//   partida       start-report request, only honoured while idle
//   andar_atual   current floor, latched when the report starts
//   item_tipo     RAM object type at item_addr (2'b00 = empty slot)
//   item_destino  RAM destination at item_addr
//   item_addr     RAM read address (combinational read port)
//   TX            serial output, idle high
//   ocupado       report in progress
//   pronto        one-cycle pulse once the trailer stop bit has finished
//   db_estado     current state encoding, for debug
// -----------------------------------------------------------------------------
module tx_relatorio_serial_8n1 #(
    parameter int BAUD_DIV = 434,
    parameter int N_ITENS  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [1:0] andar_atual,
    input  logic [1:0] item_tipo,
    input  logic [1:0] item_destino,
    output logic [3:0] item_addr,
    output logic       TX,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    ADDR_LAST = 4'(N_ITENS - 1);
    localparam logic [3:0]    BIT_STOP  = 4'd9;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        TRANSMITE = 3'd1,
        ITENS     = 3'd2,
        AVANCA    = 3'd3,
        TRAILER   = 3'd4,
        FIM       = 3'd5
    } estado_t;

    estado_t       estado_q, estado_d;
    estado_t       prox_q, prox_d;      // where TRANSMITE goes after the stop bit
    logic [8:0]    shift_q, shift_d;    // remaining data bits plus stop bit, LSB next
    logic [3:0]    bit_q, bit_d;        // 0 = start bit ... 9 = stop bit
    logic [BW-1:0] baud_q, baud_d;
    logic [1:0]    andar_q, andar_d;
    logic [3:0]    addr_q, addr_d;
    logic          tx_q, tx_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;

    // Frame-load request shared by OCIOSO, ITENS and TRAILER
    logic          carga;
    logic [7:0]    byte_carga;

    always_comb begin
        estado_d   = estado_q;
        prox_d     = prox_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        baud_d     = baud_q;
        andar_d    = andar_q;
        addr_d     = addr_q;
        tx_d       = 1'b1;
        ocupado_d  = ocupado_q;
        pronto_d   = 1'b0;
        carga      = 1'b0;
        byte_carga = 8'h00;

        case (estado_q)
            OCIOSO: begin
                ocupado_d = 1'b0;
                if (partida) begin
                    andar_d    = andar_atual;
                    addr_d     = 4'd0;
                    ocupado_d  = 1'b1;
                    prox_d     = ITENS;
                    carga      = 1'b1;
                    byte_carga = {2'b11, 2'b00, 2'b00, andar_atual};
                end
            end

            TRANSMITE: begin
                tx_d = tx_q;
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_STOP) begin
                        // Stop bit finished: line returns to idle-high
                        estado_d = prox_q;
                        tx_d     = 1'b1;
                        if (prox_q == FIM) begin
                            // pronto rises and ocupado falls together
                            pronto_d  = 1'b1;
                            ocupado_d = 1'b0;
                            addr_d    = 4'd0;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b1, shift_q[8:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            ITENS: begin
                // RAM read is combinational, so the slot is sampled right here
                if (item_tipo != 2'b00) begin
                    carga      = 1'b1;
                    byte_carga = {2'b00, item_tipo, item_destino, andar_q};
                    prox_d     = AVANCA;
                end else begin
                    estado_d = AVANCA;
                end
            end

            AVANCA: begin
                if (addr_q == ADDR_LAST) begin
                    estado_d = TRAILER;
                end else begin
                    addr_d   = addr_q + 4'd1;
                    estado_d = ITENS;
                end
            end

            TRAILER: begin
                carga      = 1'b1;
                byte_carga = 8'hFE;
                prox_d     = FIM;
            end

            FIM: begin
                estado_d  = OCIOSO;
                ocupado_d = 1'b0;
                addr_d    = 4'd0;
            end

            default: begin
                estado_d  = OCIOSO;
                prox_d    = OCIOSO;
                ocupado_d = 1'b0;
                addr_d    = 4'd0;
            end
        endcase

        // Start a frame: TX goes to the start bit on the next clock and the
        // baud counter begins a fresh bit period.
        if (carga) begin
            estado_d = TRANSMITE;
            shift_d  = {1'b1, byte_carga};
            bit_d    = 4'd0;
            baud_d   = '0;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= OCIOSO;
            prox_q    <= OCIOSO;
            shift_q   <= '0;
            bit_q     <= 4'd0;
            baud_q    <= '0;
            andar_q   <= 2'b00;
            addr_q    <= 4'd0;
            tx_q      <= 1'b1;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            prox_q    <= prox_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            baud_q    <= baud_d;
            andar_q   <= andar_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign item_addr = addr_q;
    assign TX        = tx_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = {1'b0, estado_q};

endmodule

// File: tb/tb_tx_relatorio_serial_8n1.sv
// -----------------------------------------------------------------------------
// tb_tx_relatorio_serial_8n1
//
// Bench for tx_relatorio_serial_8n1 with BAUD_DIV=4, N_ITENS=4. A small RAM
// model feeds the content port; a line monitor decodes TX frames and pops the
// expected byte queue filled by each scenario before it starts a report.
// -----------------------------------------------------------------------------
module tb_tx_relatorio_serial_8n1;

    localparam int BD = 4;
    localparam int NI = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       partida = 1'b0;
    logic [1:0] andar_atual = 2'b00;
    logic [1:0] item_tipo;
    logic [1:0] item_destino;
    logic [3:0] item_addr;
    logic       TX;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [1:0] tipo_mem [NI];
    logic [1:0] dest_mem [NI];

    int         checks = 0;
    int         failures = 0;
    int         rx_count = 0;
    logic [7:0] exp_q [$];
    logic [3:0] visit_q [$];

    always #5 clock = ~clock;

    assign item_tipo    = (item_addr[3:2] == 2'b00) ? tipo_mem[item_addr[1:0]] : 2'b00;
    assign item_destino = (item_addr[3:2] == 2'b00) ? dest_mem[item_addr[1:0]] : 2'b00;

    tx_relatorio_serial_8n1 #(.BAUD_DIV(BD), .N_ITENS(NI)) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .andar_atual  (andar_atual),
        .item_tipo    (item_tipo),
        .item_destino (item_destino),
        .item_addr    (item_addr),
        .TX           (TX),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    // Line monitor: frame offset 0 is the first low sample of the start bit;
    // every bit is sampled mid-period.
    initial begin : monitor
        int         off;
        logic       busy;
        logic [7:0] b;
        logic [7:0] e;
        off  = 0;
        busy = 1'b0;
        b    = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset) begin
                busy = 1'b0;
                off  = 0;
            end else if (!busy) begin
                if (TX === 1'b0) begin
                    busy = 1'b1;
                    off  = 1;
                end
            end else begin
                if ((off % BD) == BD / 2 && off / BD >= 1 && off / BD <= 8)
                    b[off / BD - 1] = TX;
                if (off == 9 * BD + BD / 2) begin
                    checks++;
                    if (TX !== 1'b1) begin
                        failures++;
                        $display("FAIL stop_bit got=%b want=1", TX);
                    end
                    rx_count++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_byte got=%h want=none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            failures++;
                            $display("FAIL rx_byte got=%h want=%h", b, e);
                        end
                    end
                end
                off++;
                if (off == 10 * BD) busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mem();
        for (int i = 0; i < NI; i++) begin
            tipo_mem[i] = 2'b00;
            dest_mem[i] = 2'b00;
        end
    endtask

    // Reference report for the current RAM contents and a given floor
    task automatic push_model(input logic [1:0] floor);
        exp_q.push_back({2'b11, 4'b0000, floor});
        for (int i = 0; i < NI; i++)
            if (tipo_mem[i] != 2'b00)
                exp_q.push_back({2'b00, tipo_mem[i], dest_mem[i], floor});
        exp_q.push_back(8'hFE);
    endtask

    // Returns on the first negedge after partida was sampled
    task automatic start_report(input logic [1:0] floor);
        @(negedge clock);
        andar_atual = floor;
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        int pr;
        int bad_ocp;
        bit done;
        n = 0; pr = 0; bad_ocp = 0; done = 1'b0;
        visit_q.delete();
        while (!done && n < 4000) begin
            @(negedge clock);
            n++;
            if (db_estado == 4'd2) visit_q.push_back(item_addr);
            if (pronto === 1'b1) begin
                done = 1'b1;
                pr++;
                checks++;
                if (ocupado !== 1'b0 || item_addr !== 4'd0 || db_estado !== 4'd5) begin
                    failures++;
                    $display("FAIL %s_fim got=ocp%b addr%0d st%0d want=ocp0 addr0 st5",
                             name, ocupado, item_addr, db_estado);
                end
            end else if (ocupado !== 1'b1) begin
                bad_ocp++;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout got=no_pronto want=pronto", name);
        end
        for (int k = 0; k < 2 * BD; k++) begin
            @(negedge clock);
            if (pronto === 1'b1) pr++;
        end
        checks++;
        if (pr != 1) begin
            failures++;
            $display("FAIL %s_pronto_count got=%0d want=1", name, pr);
        end
        checks++;
        if (bad_ocp != 0) begin
            failures++;
            $display("FAIL %s_ocupado got=%0d_low_cycles want=0", name, bad_ocp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        checks++;
        if (TX !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 ||
            item_addr !== 4'd0 || db_estado !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got=tx%b ocp%b pr%b addr%0d st%0d want=tx1 ocp0 pr0 addr0 st0",
                     TX, ocupado, pronto, item_addr, db_estado);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (TX !== 1'b1 || db_estado !== 4'd0 || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=tx%b st%0d ocp%b want=tx1 st0 ocp0",
                     TX, db_estado, ocupado);
        end
    endtask

    task automatic test_all_empty();
        clear_mem();
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hFE);
        start_report(2'b10);
        wait_done("all_empty");
        checks++;
        if (visit_q.size() != NI) begin
            failures++;
            $display("FAIL all_empty_scan got=%0d want=%0d", visit_q.size(), NI);
        end
    endtask

    task automatic test_slots_1_3();
        int rx0;
        clear_mem();
        tipo_mem[1] = 2'b01; dest_mem[1] = 2'b11;
        tipo_mem[3] = 2'b10; dest_mem[3] = 2'b00;
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'h1D);
        exp_q.push_back(8'h21);
        exp_q.push_back(8'hFE);
        rx0 = rx_count;
        start_report(2'b01);
        wait_done("slots_1_3");
        checks++;
        if (rx_count - rx0 != 4) begin
            failures++;
            $display("FAIL slots_1_3_frames got=%0d want=4", rx_count - rx0);
        end
    endtask

    task automatic test_all_full();
        logic [3:0] want;
        clear_mem();
        for (int i = 0; i < NI; i++) begin
            tipo_mem[i] = 2'b11;
            dest_mem[i] = 2'b10;
        end
        exp_q.push_back(8'hC0);
        for (int i = 0; i < NI; i++) exp_q.push_back(8'h38);
        exp_q.push_back(8'hFE);
        start_report(2'b00);
        wait_done("all_full");
        checks++;
        if (visit_q.size() != NI) begin
            failures++;
            $display("FAIL all_full_visits got=%0d want=%0d", visit_q.size(), NI);
        end else begin
            for (int i = 0; i < NI; i++) begin
                want = 4'(i);
                checks++;
                if (visit_q[i] !== want) begin
                    failures++;
                    $display("FAIL all_full_addr got=%0d want=%0d", visit_q[i], want);
                end
            end
        end
    endtask

    task automatic test_restart_ignored();
        int rx0;
        int n;
        int bad;
        clear_mem();
        tipo_mem[0] = 2'b01; dest_mem[0] = 2'b10;
        tipo_mem[2] = 2'b11; dest_mem[2] = 2'b01;
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h18);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'hFE);
        start_report(2'b00);
        repeat (10) @(negedge clock);
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
        n = 0;
        while (db_estado !== 4'd2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        andar_atual = 2'b11;
        wait_done("restart");
        rx0 = rx_count;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (db_estado !== 4'd0 || TX !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || rx_count != rx0) begin
            failures++;
            $display("FAIL restart_extra_report got=%0d_busy %0d_frames want=0 0",
                     bad, rx_count - rx0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int pr;
        int bad;
        clear_mem();
        tipo_mem[0] = 2'b10; dest_mem[0] = 2'b01;
        push_model(2'b01);
        start_report(2'b01);
        n = 0;
        while (db_estado !== 4'd2 && n < 200) begin @(negedge clock); n++; end
        while (db_estado !== 4'd1 && n < 400) begin @(negedge clock); n++; end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL reset_mid_no_item got=timeout want=item_frame");
        end
        repeat (4 * BD + 2) @(negedge clock);
        #1 reset = 1'b0;
        #1;
        checks++;
        if (TX !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b0 ||
            db_estado !== 4'd0 || item_addr !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_abort got=tx%b ocp%b pr%b st%0d addr%0d want=tx1 ocp0 pr0 st0 addr0",
                     TX, ocupado, pronto, db_estado, item_addr);
        end
        exp_q.delete();
        pr = 0;
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (pronto === 1'b1) pr++;
        end
        reset = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (pronto === 1'b1) pr++;
            if (db_estado !== 4'd0 || TX !== 1'b1) bad++;
        end
        checks++;
        if (pr != 0 || bad != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet got=%0d_pronto %0d_busy want=0 0", pr, bad);
        end
        clear_mem();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hFE);
        start_report(2'b11);
        wait_done("after_reset");
    endtask

    task automatic test_bit_timing();
        logic txs [10 * BD];
        int   bad;
        int   lows;
        int   highs;
        int   gap;
        bit   seen;
        clear_mem();
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hFE);
        @(negedge clock);
        andar_atual = 2'b01;
        partida = 1'b1;
        bad = 0;
        for (int off = 0; off < 10 * BD; off++) begin
            @(negedge clock);
            if (off == 0) partida = 1'b0;
            txs[off] = TX;
            if (db_estado !== 4'd1) bad++;
        end
        @(negedge clock);
        checks++;
        if (bad != 0 || db_estado === 4'd1) begin
            failures++;
            $display("FAIL frame_length got=%0d_off %0d_after want=0 not1", bad, db_estado);
        end
        lows = 0;
        while (lows < 10 * BD && txs[lows] === 1'b0) lows++;
        checks++;
        if (lows != BD) begin
            failures++;
            $display("FAIL start_bit_len got=%0d want=%0d", lows, BD);
        end
        highs = 0;
        for (int off = 9 * BD; off < 10 * BD; off++)
            if (txs[off] === 1'b1) highs++;
        checks++;
        if (highs != BD) begin
            failures++;
            $display("FAIL stop_bit_len got=%0d want=%0d", highs, BD);
        end
        gap = 0;
        seen = 1'b0;
        if (TX === 1'b1) gap = 1;
        while (!seen && gap < 500) begin
            @(negedge clock);
            if (TX === 1'b0) seen = 1'b1;
            else gap++;
        end
        checks++;
        if (!seen || gap < 2) begin
            failures++;
            $display("FAIL idle_gap got=%0d want=>=2", gap);
        end
        wait_done("bit_timing");
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_all_empty();
        test_slots_1_3();
        test_all_full();
        test_restart_ignored();
        test_reset_mid();
        test_bit_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
